bitserial_adder: RTL

- Bit-serial WIDTH-bit adder: the additive counterpart of the team's gate-level subtractor cells.
- One full-adder slice with a registered carry processes the operands LSB-first, one bit per clock.
- Control is start/busy/done.
- Used where area matters more than latency, and as the golden serial reference for the combinational adder/subtractor cells.

---
 rtl/bitserial_adder_if.sv | 24 ++
 rtl/bitserial_adder.sv | 89 ++++++++
 2 files changed

// File: rtl/bitserial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered sum/carry out.
interface bitserial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bitserial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice with a registered carry, LSB first.
// Latency WIDTH cycles from the accepting edge to done; start is ignored while busy.
module bitserial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bitserial_adder_if.slave   bus
);

    localparam int             CW   = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_r_next;

    assign w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c      = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    assign w_r_next = {w_s, r_r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_r_sr  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_carry <= w_c;
                    r_r_sr  <= w_r_next;
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    // Final bit: publish the full result on this same edge.
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_sum   <= w_r_next;
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
